// File: rtl/bin_to_digits_pkg.sv
// Shared types and constants for the binary-to-display-digit converter.
package bin_to_digits_pkg;

  localparam int          DIG_W        = 4;
  localparam int          N_DIG        = 6;
  localparam int          VAL_W        = DIG_W * N_DIG;
  localparam int          DEF_MAX_DEC  = 999999;
  localparam logic [3:0]  DEF_ERR_CODE = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble corrector: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bin_to_digits_pkg::*;
(
  input  logic [DIG_W-1:0] i_nib,
  output logic [DIG_W-1:0] o_nib
);

  assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin_to_digits.sv
// Converts a 24-bit binary value into six 4-bit display digit codes, either
// as a direct hex nibble split or as an iterative double-dabble decimal
// conversion. Result registers only change on completion, so the display
// never sees a half-converted value.
module bin_to_digits
  import bin_to_digits_pkg::*;
#(
  parameter int         BIN_W    = 20,
  parameter int         MAX_DEC  = DEF_MAX_DEC,
  parameter logic [3:0] ERR_CODE = DEF_ERR_CODE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode_hex,
  input  logic [VAL_W-1:0] value,
  output logic [DIG_W-1:0] data0,
  output logic [DIG_W-1:0] data1,
  output logic [DIG_W-1:0] data2,
  output logic [DIG_W-1:0] data3,
  output logic [DIG_W-1:0] data4,
  output logic [DIG_W-1:0] data5,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int               CNT_W     = $clog2(BIN_W);
  localparam logic [VAL_W-1:0] MAX_V     = VAL_W'(MAX_DEC);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIN_W - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [VAL_W-1:0]   r_value;
  logic               r_mode_hex;
  logic [BIN_W-1:0]   r_shift;
  logic [VAL_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic [VAL_W-1:0]   r_digits;
  logic               r_done;
  logic               r_ovf;
  logic [VAL_W-1:0]   w_bcd_adj;
  logic               w_short;

  // Hex requests and out-of-range decimal requests skip the iteration phase.
  assign w_short = mode_hex || (value > MAX_V);

  genvar g;
  generate
    for (g = 0; g < N_DIG; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_nib (r_bcd[g*DIG_W +: DIG_W]),
        .o_nib (w_bcd_adj[g*DIG_W +: DIG_W])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode: IDLE -> CONV for BIN_W iterations -> DONE for one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = w_short ? ST_DONE : ST_CONV;
      ST_CONV: if (r_cnt == CNT_LAST) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, double-dabble iteration and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value    <= '0;
      r_mode_hex <= 1'b0;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_digits   <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_value    <= value;
            r_mode_hex <= mode_hex;
            if (!w_short) begin
              r_shift <= value[BIN_W-1:0];
              r_bcd   <= '0;
              r_cnt   <= '0;
            end
          end
        end
        ST_CONV: begin
          // The corrected accumulator MSB falls off the top; it is never set
          // for inputs within the decimal range.
          {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
          r_cnt            <= r_cnt + CNT_W'(1);
        end
        ST_DONE: begin
          r_done <= 1'b1;
          if (r_mode_hex) begin
            r_digits <= r_value;
            r_ovf    <= 1'b0;
          end else if (r_value > MAX_V) begin
            r_digits <= {N_DIG{ERR_CODE}};
            r_ovf    <= 1'b1;
          end else begin
            r_digits <= r_bcd;
            r_ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != ST_IDLE);
  assign done  = r_done;
  assign ovf   = r_ovf;
  assign data0 = r_digits[23:20];
  assign data1 = r_digits[19:16];
  assign data2 = r_digits[15:12];
  assign data3 = r_digits[11:8];
  assign data4 = r_digits[7:4];
  assign data5 = r_digits[3:0];

endmodule
